// File: rtl/x_or_reduce_pipe.sv
// Pipelined WIDTH-input OR reduction built from registered FANIN-input OR nodes,
// with a valid pipeline, clock enable, sticky event flag and per-bit capture.
module x_or_reduce_pipe #(
    parameter int WIDTH     = 9,
    parameter int FANIN     = 4,
    parameter bit STICKY_EN = 1'b1,
    parameter     LOC       = "UNPLACED"
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    input  logic             IVALID,
    input  logic             CLR,
    output logic             O,
    output logic             OVALID,
    output logic             STICKY_O,
    output logic [WIDTH-1:0] CAP
);

    function automatic int level_width(input int k);
        int n;
        n = WIDTH;
        for (int i = 32'sd0; i < k; i++) begin
            n = (n + FANIN - 32'sd1) / FANIN;
        end
        return n;
    endfunction

    function automatic int calc_latency();
        int n;
        int l;
        n = WIDTH;
        l = 32'sd0;
        // A single-bit input still gets one register stage.
        for (int i = 32'sd0; i < 32'sd16; i++) begin
            if ((l == 32'sd0) || (n > 32'sd1)) begin
                n = (n + FANIN - 32'sd1) / FANIN;
                l = l + 32'sd1;
            end
        end
        return l;
    endfunction

    localparam int LAT = calc_latency();

    for (genvar k = 1; k <= LAT; k++) begin : g_lvl
        localparam int NW   = level_width(k);
        localparam int PW   = level_width(k - 1);
        localparam int PADW = NW * FANIN;

        logic [PW-1:0]   src_s;
        logic            src_vld_s;
        logic [PADW-1:0] pad_s;
        logic [NW-1:0]   node_s;
        logic [NW-1:0]   data_r;
        logic            valid_r;

        if (k == 1) begin : g_first
            assign src_s     = I;
            assign src_vld_s = IVALID;
        end else begin : g_next
            assign src_s     = g_lvl[k-1].data_r;
            assign src_vld_s = g_lvl[k-1].valid_r;
        end

        // Inputs missing from a partial last node read as zero.
        assign pad_s = PADW'(src_s);

        // One OR node per FANIN-wide group of the previous level.
        always_comb begin
            node_s = {NW{1'b0}};
            for (int j = 32'sd0; j < NW; j++) begin
                node_s[j] = |pad_s[j*FANIN +: FANIN];
            end
        end

        // Level register: data loads regardless of valid, both freeze when CE is low.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                data_r  <= {NW{1'b0}};
                valid_r <= 1'b0;
            end else if (CE) begin
                data_r  <= node_s;
                valid_r <= src_vld_s;
            end
        end
    end

    assign O      = g_lvl[LAT].data_r[0];
    assign OVALID = g_lvl[LAT].valid_r;

    if (STICKY_EN) begin : g_sticky
        logic             sticky_r;
        logic [WIDTH-1:0] cap_r;

        // Sticky flag: a new valid O=1 event wins over a simultaneous clear.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                sticky_r <= 1'b0;
            end else if (CE && OVALID && O) begin
                sticky_r <= 1'b1;
            end else if (CLR) begin
                sticky_r <= 1'b0;
            end
        end

        // Capture: on clear-with-accumulate only the new sample's bits survive.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                cap_r <= {WIDTH{1'b0}};
            end else if (CE && IVALID) begin
                cap_r <= CLR ? I : (cap_r | I);
            end else if (CLR) begin
                cap_r <= {WIDTH{1'b0}};
            end
        end

        assign STICKY_O = sticky_r;
        assign CAP      = cap_r;
    end else begin : g_no_sticky
        assign STICKY_O = 1'b0;
        assign CAP      = {WIDTH{1'b0}};
    end

endmodule

// File: doc/x_or_reduce_pipe.md
Name: x_or_reduce_pipe

Overview:
- Parametrised, pipelined successor to the fixed 9-input OR primitive.
- Reduces a WIDTH-bit input vector to one OR bit through a registered tree of FANIN-input OR nodes, with a valid pipeline and clock enable.
- Adds a sticky event flag and a per-bit capture register, both cleared by CLR.
- Used in timing-closed simulation models and as an error/interrupt aggregator.

Parameters:
- WIDTH, 9: number of input bits; legal range 1..256.
- FANIN, 4: inputs per OR tree node; legal range 2..8.
- STICKY_EN, 1: 1 enables STICKY_O and CAP; 0 ties both to 0 permanently.
- LOC, "UNPLACED": placement attribute; no functional effect.

Ports:
- CLK  input  1  rising-edge clock.
- RSTN  input  1  asynchronous, active-low reset.
- CE  input  1  clock enable; low freezes the pipeline.
- I  input  WIDTH  input vector.
- IVALID  input  1  I qualifier.
- CLR  input  1  synchronous clear of STICKY_O and CAP.
- O  output  1  registered OR of I, delayed by latency L.
- OVALID  output  1  O qualifier.
- STICKY_O  output  1  set once any valid O=1 is seen; held until CLR.
- CAP  output  WIDTH  accumulated OR of every valid I since the last CLR.

Behaviour:
- Reset: RSTN low asynchronously forces O, OVALID, STICKY_O, CAP and all internal tree/valid registers to 0. Release is synchronous to CLK.
- Latency L, defined by iteration:
  - Start with n = WIDTH, L = 0.
  - Repeat: n = ceil(n/FANIN), L = L+1, until n == 1.
  - WIDTH=1 gives L=1; WIDTH=9, FANIN=4 gives L=2; WIDTH=16, FANIN=4 gives L=2; WIDTH=17, FANIN=4 gives L=3.
- Tree structure:
  - Level k node j ORs inputs j*FANIN .. j*FANIN+FANIN-1 of level k-1.
  - Missing inputs in a partial last node are 0.
  - Every level is registered.
- Valid pipeline:
  - Each level has a valid bit. Stage 0 loads IVALID.
  - Data registers load regardless of valid. O is meaningful only when OVALID=1.
  - Invalid samples propagate as bubbles.
- CE:
  - CE=0 freezes all tree and valid registers and suppresses STICKY_O set and CAP accumulate. No data is lost or duplicated.
  - CE=1 advances every stage one level per cycle.
  - A sample with IVALID=1 and CE=1 at edge t appears with OVALID=1 after L enabled edges.
- STICKY_O (STICKY_EN=1): at an edge with CE=1, OVALID=1 and O=1 (values before the edge), STICKY_O becomes 1.
- CAP (STICKY_EN=1): at an edge with CE=1 and IVALID=1, CAP <= CAP | I.
- CLR:
  - Acts on STICKY_O and CAP at the edge irrespective of CE. Does not affect O, OVALID or the tree.
  - CLR with a simultaneous set/accumulate event: the new event wins. STICKY_O <= 1; CAP <= I (old bits dropped, new bits kept).
- Reset mid-operation: in-flight samples are discarded. OVALID stays 0 for L enabled edges after release.
- No backpressure. A new sample may be accepted every enabled cycle (throughput 1/cycle).

Test Plan:
- Reset/latency: WIDTH=9, FANIN=4. Hold RSTN=0 with I=9'h1FF, IVALID=1 → all outputs 0. Release RSTN; CE=1 → OVALID=1, O=1 at the 2nd edge after release.
- Streaming: I = 9'h000, 9'h100, 9'h000, 9'h001 on consecutive cycles, IVALID=1 → O = 0,1,0,1 with exactly 2-cycle latency and OVALID continuously 1.
- Bubbles/CE: same stream with IVALID=0 on cycle 2 and CE=0 for 3 cycles mid-stream → O/OVALID sequence shows one bubble, holds its values during the stall, no duplicated or missing sample.
- Sticky/CAP: I = 9'h004 then 9'h080 (valid), then zeros → CAP=9'h084 and STICKY_O=1 from the first O=1 edge. CLR pulse → both 0.
- CLR collision: CLR=1 in the same cycle as valid I=9'h010 with CAP=9'h084 → CAP=9'h010. CLR in the same cycle as OVALID&O=1 → STICKY_O=1.
- Width sweep: WIDTH in {1, 16, 17, 256}, FANIN in {2, 4, 8}, random I → O equals |I delayed by the computed L. Async reset asserted mid-stream → OVALID returns to 0 immediately.
